// File: rtl/mem_bus_pkg.sv
// Shared types and default memory map for the core memory-bus controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_bus_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Fault cause encodings reported on fault_cause
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_UNMAPPED = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

  // Standard map, bank 0 in the least-significant slice:
  // bank 0 data RAM, bank 1 VGA text RAM, bank 2 I/O, bank 3 stack
  localparam logic [127:0] DEF_BASE_VEC      = {32'h7FFFE000, 32'hFFFF0000, 32'h10010000, 32'h10000000};
  localparam logic [19:0]  DEF_SIZE_LOG2_VEC = {5'd8, 5'd8, 5'd13, 5'd13};
  localparam logic [15:0]  DEF_LAT_VEC       = {4'd0, 4'd2, 4'd1, 4'd0};

  // Bank index width; a single-bank build still gets a 1-bit select
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_decoder.sv
// Address decoder: per-bank window hit, lowest-index priority, word offset.
// Latency: purely combinational.
// Backpressure: none; the controller decides what to do with a miss.
module mem_bank_decoder
  import mem_bus_pkg::*;
#(
  parameter int                       NBANKS        = 4,
  parameter int                       ADDR_W        = 32,
  parameter int                       PHYS_W        = 13,
  parameter int                       SEL_W         = sel_width(NBANKS),
  parameter logic [NBANKS*ADDR_W-1:0] BASE_VEC      = DEF_BASE_VEC,
  parameter logic [NBANKS*5-1:0]      SIZE_LOG2_VEC = DEF_SIZE_LOG2_VEC
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [SEL_W-1:0]  o_sel,
  output logic [PHYS_W-3:0] o_word_addr
);

  // Scan from the top bank down so the lowest matching index is the one left standing
  always_comb begin
    o_hit       = 1'b0;
    o_sel       = '0;
    o_word_addr = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if ((i_addr >> SIZE_LOG2_VEC[5*i +: 5]) ==
          (BASE_VEC[ADDR_W*i +: ADDR_W] >> SIZE_LOG2_VEC[5*i +: 5])) begin
        o_hit       = 1'b1;
        o_sel       = SEL_W'(i);
        // Offset inside the window, dropped to a word address; the window
        // never exceeds the physical span so no high bits are lost
        o_word_addr = (PHYS_W-2)'((i_addr & ((ADDR_W'(1) << SIZE_LOG2_VEC[5*i +: 5]) - ADDR_W'(1))) >> 2);
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Load/store bus controller: decodes to N banks, inserts per-bank wait states, flags faults.
// Latency: zero-wait banks complete in the request cycle; LAT=L banks stall the core exactly L cycles.
// Backpressure: cpu_stall holds the core; unmapped or timed-out accesses stall until fault_clr.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                       NBANKS        = 4,
  parameter int                       ADDR_W        = 32,
  parameter int                       DATA_W        = 32,
  parameter int                       PHYS_W        = 13,
  parameter logic [NBANKS*ADDR_W-1:0] BASE_VEC      = DEF_BASE_VEC,
  parameter logic [NBANKS*5-1:0]      SIZE_LOG2_VEC = DEF_SIZE_LOG2_VEC,
  parameter logic [NBANKS*4-1:0]      LAT_VEC       = DEF_LAT_VEC,
  parameter int                       TIMEOUT       = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic [DATA_W/8-1:0]           cpu_be,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_stall,
  output logic                          cpu_fault,
  output logic [1:0]                    fault_cause,
  input  logic                          fault_clr,
  output logic [NBANKS-1:0]             bank_en,
  output logic [DATA_W/8-1:0]           bank_be,
  output logic [PHYS_W-3:0]             bank_addr,
  output logic [DATA_W-1:0]             bank_wdata,
  input  logic [NBANKS*DATA_W-1:0]      bank_rdata,
  output logic [sel_width(NBANKS)-1:0]  bank_sel
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = sel_width(NBANKS);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic [WD_W-1:0]   r_wdog;
  logic [SEL_W-1:0]  r_sel;
  logic [PHYS_W-3:0] r_word_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_fault;
  logic [1:0]        r_cause;

  state_t            w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic [WD_W-1:0]   w_wdog_nxt;
  logic              w_load;
  logic              w_fault_nxt;
  logic [1:0]        w_cause_nxt;
  logic              w_done;
  logic              w_hit;
  logic [SEL_W-1:0]  w_dec_sel;
  logic [PHYS_W-3:0] w_dec_word;
  logic [3:0]        w_lat;

  mem_bank_decoder #(
    .NBANKS        (NBANKS),
    .ADDR_W        (ADDR_W),
    .PHYS_W        (PHYS_W),
    .SEL_W         (SEL_W),
    .BASE_VEC      (BASE_VEC),
    .SIZE_LOG2_VEC (SIZE_LOG2_VEC)
  ) u_dec (
    .i_addr      (cpu_addr),
    .o_hit       (w_hit),
    .o_sel       (w_dec_sel),
    .o_word_addr (w_dec_word)
  );

  // Wait-state count of the bank currently being decoded
  always_comb begin
    w_lat = 4'd0;
    for (int i = 0; i < NBANKS; i++) begin
      if (w_dec_sel == SEL_W'(i)) w_lat = LAT_VEC[4*i +: 4];
    end
  end

  // Next-state, counters, fault bookkeeping and bank-side outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    w_wdog_nxt  = r_wdog;
    w_load      = 1'b0;
    w_fault_nxt = r_fault;
    w_cause_nxt = r_cause;
    w_done      = 1'b0;
    cpu_stall   = 1'b0;
    bank_en     = '0;
    bank_be     = '0;
    bank_addr   = '0;
    bank_wdata  = '0;
    bank_sel    = '0;

    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_hit) begin
            bank_en    = NBANKS'(1) << w_dec_sel;
            bank_sel   = w_dec_sel;
            bank_addr  = w_dec_word;
            bank_wdata = cpu_wdata;
            if (w_lat == 4'd0) begin
              bank_be = cpu_be;
              w_done  = 1'b1;
            end else begin
              // Write enables are withheld until the completing cycle
              cpu_stall   = 1'b1;
              w_load      = 1'b1;
              w_cnt_nxt   = w_lat - 4'd1;
              w_wdog_nxt  = '0;
              w_state_nxt = WAIT;
            end
          end else begin
            cpu_stall   = 1'b1;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FC_UNMAPPED;
            w_state_nxt = FAULT;
          end
        end
      end

      WAIT: begin
        // Replay the captured request; cpu_req is deliberately not looked at
        bank_en    = NBANKS'(1) << r_sel;
        bank_sel   = r_sel;
        bank_addr  = r_word_addr;
        bank_wdata = r_wdata;
        if (r_wait_cnt == 4'd0) begin
          bank_be     = r_be;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          cpu_stall = 1'b1;
          w_cnt_nxt = r_wait_cnt - 4'd1;
          if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            w_fault_nxt = 1'b1;
            w_cause_nxt = FC_TIMEOUT;
            w_state_nxt = FAULT;
          end else begin
            w_wdog_nxt = r_wdog + 1'b1;
          end
        end
      end

      FAULT: begin
        cpu_stall = 1'b1;
        if (fault_clr) begin
          w_fault_nxt = 1'b0;
          w_cause_nxt = FC_NONE;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // While reset is held every output is quiet, even mid-access
    if (!reset) begin
      w_done     = 1'b0;
      cpu_stall  = 1'b0;
      bank_en    = '0;
      bank_be    = '0;
      bank_addr  = '0;
      bank_wdata = '0;
      bank_sel   = '0;
    end
  end

  // Read data is steered only in a completing cycle, zero otherwise
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (w_done && (bank_sel == SEL_W'(i))) cpu_rdata = bank_rdata[DATA_W*i +: DATA_W];
    end
  end

  // State, counters, captured request and sticky fault registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_wdog      <= '0;
      r_sel       <= '0;
      r_word_addr <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_fault     <= 1'b0;
      r_cause     <= FC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_wdog     <= w_wdog_nxt;
      r_fault    <= w_fault_nxt;
      r_cause    <= w_cause_nxt;
      if (w_load) begin
        r_sel       <= w_dec_sel;
        r_word_addr <= w_dec_word;
        r_be        <= cpu_be;
        r_wdata     <= cpu_wdata;
      end
    end
  end

  assign cpu_fault   = r_fault;
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: default map instance plus a short-watchdog instance.
// Inputs change at the falling edge; outputs are checked 1ns later.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_mem_bus_ctrl;

  logic         clk;
  logic         rst_n;
  logic [127:0] brd;

  // default-map instance stimulus / observation
  logic         req, clr;
  logic [3:0]   be;
  logic [31:0]  addr, wdata;
  logic [31:0]  rdata;
  logic         stall, fault;
  logic [1:0]   cause;
  logic [3:0]   ben, bbe;
  logic [10:0]  baddr;
  logic [31:0]  bwdata;
  logic [1:0]   bsel;

  // watchdog instance stimulus / observation
  logic         wd_req, wd_clr;
  logic [3:0]   wd_be;
  logic [31:0]  wd_addr, wd_wdata;
  logic [31:0]  wd_rdata;
  logic         wd_stall, wd_fault;
  logic [1:0]   wd_cause;
  logic [3:0]   wd_ben, wd_bbe;
  logic [10:0]  wd_baddr;
  logic [31:0]  wd_bwdata;
  logic [1:0]   wd_bsel;

  int checks = 0;
  int errors = 0;

  mem_bus_ctrl u_dut (
    .clk(clk), .reset(rst_n), .cpu_req(req), .cpu_be(be), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_stall(stall), .cpu_fault(fault),
    .fault_cause(cause), .fault_clr(clr), .bank_en(ben), .bank_be(bbe),
    .bank_addr(baddr), .bank_wdata(bwdata), .bank_rdata(brd), .bank_sel(bsel)
  );

  mem_bus_ctrl #(
    .LAT_VEC ({4'd0, 4'd15, 4'd1, 4'd0}),
    .TIMEOUT (8)
  ) u_wd (
    .clk(clk), .reset(rst_n), .cpu_req(wd_req), .cpu_be(wd_be), .cpu_addr(wd_addr),
    .cpu_wdata(wd_wdata), .cpu_rdata(wd_rdata), .cpu_stall(wd_stall), .cpu_fault(wd_fault),
    .fault_cause(wd_cause), .fault_clr(wd_clr), .bank_en(wd_ben), .bank_be(wd_bbe),
    .bank_addr(wd_baddr), .bank_wdata(wd_bwdata), .bank_rdata(brd), .bank_sel(wd_bsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge; caller then drives inputs and checks after #1
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    brd      = {32'h44445555, 32'h22223333, 32'hDEADBEEF, 32'h11110000};
    rst_n    = 1'b0;
    req = 1'b0; clr = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    wd_req = 1'b0; wd_clr = 1'b0; wd_be = 4'h0; wd_addr = 32'h0; wd_wdata = 32'h0;

    // reset state
    repeat (2) nxt();
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_cause", {30'b0, cause}, 32'd0);
    chk("rst_en",    {28'b0, ben},   32'd0);
    chk("rst_rdata", rdata,          32'd0);
    nxt(); rst_n = 1'b1;

    // read bank 1 (LAT=1)
    nxt(); req = 1'b1; be = 4'h0; addr = 32'h10010004; #1;
    chk("rd1_stall0", {31'b0, stall}, 32'd1);
    chk("rd1_en0",    {28'b0, ben},   32'h2);
    chk("rd1_addr0",  {21'b0, baddr}, 32'd1);
    chk("rd1_rdata0", rdata,          32'd0);
    nxt(); #1;
    chk("rd1_stall1", {31'b0, stall}, 32'd0);
    chk("rd1_rdata1", rdata,          32'hDEADBEEF);
    chk("rd1_sel1",   {30'b0, bsel},  32'd1);
    nxt(); req = 1'b0; #1;
    chk("idle_rdata", rdata,          32'd0);
    chk("idle_en",    {28'b0, ben},   32'd0);

    // write bank 0 (LAT=0)
    nxt(); req = 1'b1; be = 4'b0011; addr = 32'h10000010; wdata = 32'h0000ABCD; #1;
    chk("wr0_stall", {31'b0, stall}, 32'd0);
    chk("wr0_en",    {28'b0, ben},   32'h1);
    chk("wr0_be",    {28'b0, bbe},   32'h3);
    chk("wr0_addr",  {21'b0, baddr}, 32'd4);
    chk("wr0_wdata", bwdata,         32'h0000ABCD);

    // read bank 3 (LAT=0), top word of its window
    nxt(); be = 4'h0; addr = 32'h7FFFE0FC; #1;
    chk("rd3_stall", {31'b0, stall}, 32'd0);
    chk("rd3_en",    {28'b0, ben},   32'h8);
    chk("rd3_addr",  {21'b0, baddr}, 32'h3F);
    chk("rd3_rdata", rdata,          32'h44445555);

    // write bank 2 (LAT=2)
    nxt(); be = 4'hF; addr = 32'hFFFF0008; wdata = 32'hCAFEF00D; #1;
    chk("wr2_stallA", {31'b0, stall}, 32'd1);
    chk("wr2_enA",    {28'b0, ben},   32'h4);
    chk("wr2_beA",    {28'b0, bbe},   32'h0);
    nxt(); #1;
    chk("wr2_stallB", {31'b0, stall}, 32'd1);
    chk("wr2_beB",    {28'b0, bbe},   32'h0);
    nxt(); #1;
    chk("wr2_stallC", {31'b0, stall}, 32'd0);
    chk("wr2_beC",    {28'b0, bbe},   32'hF);
    chk("wr2_addrC",  {21'b0, baddr}, 32'd2);
    chk("wr2_wdataC", bwdata,         32'hCAFEF00D);
    nxt(); req = 1'b0; be = 4'h0; #1;
    chk("wr2_after_be", {28'b0, bbe}, 32'h0);

    // bank 2 read with cpu_req dropped during WAIT still completes
    nxt(); req = 1'b1; addr = 32'hFFFF0000; #1;
    chk("drop_stallA", {31'b0, stall}, 32'd1);
    nxt(); req = 1'b0; #1;
    chk("drop_stallB", {31'b0, stall}, 32'd1);
    nxt(); #1;
    chk("drop_stallC", {31'b0, stall}, 32'd0);
    chk("drop_rdataC", rdata,          32'h22223333);
    nxt(); #1;
    chk("drop_fault",  {31'b0, fault}, 32'd0);
    chk("drop_stallD", {31'b0, stall}, 32'd0);

    // unmapped write
    nxt(); req = 1'b1; be = 4'hF; addr = 32'h00000100; wdata = 32'h12345678; #1;
    chk("um_stall0", {31'b0, stall}, 32'd1);
    chk("um_en0",    {28'b0, ben},   32'd0);
    chk("um_be0",    {28'b0, bbe},   32'd0);
    chk("um_fault0", {31'b0, fault}, 32'd0);
    nxt(); #1;
    chk("um_fault1", {31'b0, fault}, 32'd1);
    chk("um_cause1", {30'b0, cause}, 32'd1);
    chk("um_stall1", {31'b0, stall}, 32'd1);
    chk("um_en1",    {28'b0, ben},   32'd0);
    nxt(); req = 1'b0; be = 4'h0; clr = 1'b1; #1;
    chk("um_fault_clr_cyc", {31'b0, fault}, 32'd1);
    nxt(); clr = 1'b0; #1;
    chk("um_fault_cleared", {31'b0, fault}, 32'd0);
    chk("um_cause_cleared", {30'b0, cause}, 32'd0);
    chk("um_stall_cleared", {31'b0, stall}, 32'd0);
    nxt(); req = 1'b1; addr = 32'h10010004; #1;
    chk("post_stall0", {31'b0, stall}, 32'd1);
    nxt(); #1;
    chk("post_stall1", {31'b0, stall}, 32'd0);
    chk("post_rdata1", rdata,          32'hDEADBEEF);
    nxt(); req = 1'b0;

    // fault_clr outside FAULT has no effect on a following access
    nxt(); clr = 1'b1; #1;
    chk("clr_idle_stall", {31'b0, stall}, 32'd0);
    nxt(); clr = 1'b0;

    // watchdog: bank 2 at LAT=15 against TIMEOUT=8
    nxt(); wd_req = 1'b1; wd_addr = 32'hFFFF0000; #1;
    chk("wd_stall0", {31'b0, wd_stall}, 32'd1);
    chk("wd_en0",    {28'b0, wd_ben},   32'h4);
    for (int k = 1; k <= 8; k++) begin
      nxt(); #1;
      chk($sformatf("wd_stall_w%0d", k), {31'b0, wd_stall}, 32'd1);
      chk($sformatf("wd_cause_w%0d", k), {30'b0, wd_cause}, 32'd0);
      chk($sformatf("wd_en_w%0d", k),    {28'b0, wd_ben},   32'h4);
    end
    nxt(); #1;
    chk("wd_fault",  {31'b0, wd_fault}, 32'd1);
    chk("wd_cause",  {30'b0, wd_cause}, 32'd2);
    chk("wd_en_off", {28'b0, wd_ben},   32'd0);
    chk("wd_stallF", {31'b0, wd_stall}, 32'd1);
    nxt(); wd_req = 1'b0; wd_clr = 1'b1;
    nxt(); wd_clr = 1'b0; #1;
    chk("wd_cleared", {30'b0, wd_cause}, 32'd0);

    // reset asserted in the first WAIT cycle of a bank-2 write
    nxt(); req = 1'b1; be = 4'hF; addr = 32'hFFFF0004; wdata = 32'h55AA55AA; #1;
    chk("rw_stallA", {31'b0, stall}, 32'd1);
    nxt(); rst_n = 1'b0; #1;
    chk("rw_be_in_rst", {28'b0, bbe}, 32'd0);
    chk("rw_en_in_rst", {28'b0, ben}, 32'd0);
    nxt(); rst_n = 1'b1; req = 1'b0; be = 4'h0; #1;
    chk("rw_stall", {31'b0, stall},  32'd0);
    chk("rw_en",    {28'b0, ben},    32'd0);
    chk("rw_be",    {28'b0, bbe},    32'd0);
    chk("rw_addr",  {21'b0, baddr},  32'd0);
    chk("rw_wdata", bwdata,          32'd0);
    chk("rw_rdata", rdata,           32'd0);
    chk("rw_fault", {31'b0, fault},  32'd0);
    // back in IDLE: a zero-wait read completes immediately
    nxt(); req = 1'b1; addr = 32'h10000000; #1;
    chk("rw_idle_stall", {31'b0, stall}, 32'd0);
    chk("rw_idle_rdata", rdata,          32'h11110000);
    nxt(); req = 1'b0;

    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
